// File: rtl/pkt_send_scheduler_if.sv
// Handshake bundle between the send scheduler and the two send_packet controllers.
// slave  : scheduler side (link status and receive-level in, send commands and status out).
// master : controller / environment side (mirror image of slave).
interface pkt_send_scheduler_if;
    logic        mac_inited_i;
    logic        rx_ready_i;
    logic        data_saved_2_i;
    logic        cmd_send_1_o;
    logic [24:0] start_ram_addr_1_o;
    logic        cmd_send_2_o;
    logic [24:0] start_ram_addr_2_o;
    logic [15:0] tx_count_1_o;
    logic [15:0] echo_count_o;
    logic [15:0] echo_drop_o;
    logic        first_done_o;

    modport slave (
        input  mac_inited_i, rx_ready_i, data_saved_2_i,
        output cmd_send_1_o, start_ram_addr_1_o, cmd_send_2_o, start_ram_addr_2_o,
        output tx_count_1_o, echo_count_o, echo_drop_o, first_done_o
    );

    modport master (
        output mac_inited_i, rx_ready_i, data_saved_2_i,
        input  cmd_send_1_o, start_ram_addr_1_o, cmd_send_2_o, start_ram_addr_2_o,
        input  tx_count_1_o, echo_count_o, echo_drop_o, first_done_o
    );
endinterface

// File: rtl/pkt_send_scheduler.sv
// Purpose: periodic channel-1 sends plus channel-2 echo (and optional initial) sends, gated by link readiness.
// Latency: channel-1 pulse PERIOD_1 edges after link-up; echo pulse one edge after a data_saved rise.
// Backpressure: none; rises arriving while channel 2 is not armed are counted as drops, never queued.
// Ports: clk_50_pll / main_reset (async, active-high) plain; everything else through bus (slave modport):
//   link status + data_saved_2 in; cmd_send_1/2 with start addresses out; saturating
//   tx_count_1 / echo_count / echo_drop status counters and first_done flag out.
module pkt_send_scheduler #(
    parameter logic [31:0] PERIOD_1     = 32'd100_000_000,
    parameter logic [31:0] FIRST_DELAY  = 32'd117_000_000,
    parameter logic        ALLOW_FIRST  = 1'b0,
    parameter logic [7:0]  CMD_HOLD     = 8'd3,
    parameter logic [24:0] START_ADDR_1 = 25'd1,
    parameter logic [24:0] START_ADDR_2 = 25'd5
) (
    input  logic             clk_50_pll,
    input  logic             main_reset,
    pkt_send_scheduler_if.slave bus
);

    typedef enum logic [1:0] {S1_IDLE, S1_COUNT, S1_ASSERT} ch1_state_t;
    typedef enum logic [2:0] {S2_IDLE, S2_FIRST_WAIT, S2_FIRST_HOLD,
                              S2_ARMED, S2_ECHO_HOLD, S2_WAIT_CLR} ch2_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic link_ok;
    logic rise;

    ch1_state_t  state1_q, state1_d;
    logic [31:0] cnt1_q, cnt1_d;
    logic [7:0]  hold1_q, hold1_d;
    logic        cmd_send_1_q, cmd_send_1_d;
    logic [24:0] addr1_q, addr1_d;
    logic [15:0] tx_count_1_q, tx_count_1_d;

    ch2_state_t  state2_q, state2_d;
    logic [31:0] cnt2_q, cnt2_d;
    logic [7:0]  hold2_q, hold2_d;
    logic        cmd_send_2_q, cmd_send_2_d;
    logic [24:0] addr2_q, addr2_d;
    logic [15:0] echo_count_q, echo_count_d;
    logic [15:0] echo_drop_q, echo_drop_d;
    logic        first_done_q, first_done_d;
    logic        ds_prev_q;

    assign link_ok = bus.mac_inited_i & bus.rx_ready_i;
    assign rise    = bus.data_saved_2_i & ~ds_prev_q;

    // ---------------- channel 1: periodic sender ----------------
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            state1_q     <= S1_IDLE;
            cnt1_q       <= 32'd0;
            hold1_q      <= 8'd0;
            cmd_send_1_q <= 1'b0;
            addr1_q      <= 25'd0;
            tx_count_1_q <= 16'd0;
        end else begin
            state1_q     <= state1_d;
            cnt1_q       <= cnt1_d;
            hold1_q      <= hold1_d;
            cmd_send_1_q <= cmd_send_1_d;
            addr1_q      <= addr1_d;
            tx_count_1_q <= tx_count_1_d;
        end
    end

    always_comb begin
        state1_d     = state1_q;
        cnt1_d       = cnt1_q;
        hold1_d      = hold1_q;
        tx_count_1_d = tx_count_1_q;
        case (state1_q)
            S1_IDLE: begin
                if (link_ok) begin
                    state1_d = S1_COUNT;
                    cnt1_d   = 32'd0;
                end
            end
            S1_COUNT, S1_ASSERT: begin
                if (!link_ok) begin
                    // Link loss truncates any pulse and restarts the period on restore.
                    state1_d = S1_IDLE;
                    cnt1_d   = 32'd0;
                end else begin
                    // The period counter keeps running through ASSERT so pulse starts stay PERIOD_1 apart.
                    cnt1_d = (cnt1_q == PERIOD_1 - 32'd1) ? 32'd0 : cnt1_q + 32'd1;
                    if (cnt1_q == PERIOD_1 - 32'd1) begin
                        state1_d     = S1_ASSERT;
                        hold1_d      = CMD_HOLD - 8'd1;
                        tx_count_1_d = sat_inc(tx_count_1_q);
                    end else if (state1_q == S1_ASSERT) begin
                        if (hold1_q == 8'd0) state1_d = S1_COUNT;
                        else                 hold1_d  = hold1_q - 8'd1;
                    end
                end
            end
            default: state1_d = S1_IDLE;
        endcase
        cmd_send_1_d = (state1_d == S1_ASSERT);
        // Address is captured as the pulse rises and held until the next pulse.
        addr1_d = (cmd_send_1_d && !cmd_send_1_q) ? START_ADDR_1 : addr1_q;
    end

    // ---------------- channel 2: initial send + echo ----------------
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            state2_q     <= S2_IDLE;
            cnt2_q       <= 32'd0;
            hold2_q      <= 8'd0;
            cmd_send_2_q <= 1'b0;
            addr2_q      <= 25'd0;
            echo_count_q <= 16'd0;
            echo_drop_q  <= 16'd0;
            first_done_q <= 1'b0;
            ds_prev_q    <= 1'b0;
        end else begin
            state2_q     <= state2_d;
            cnt2_q       <= cnt2_d;
            hold2_q      <= hold2_d;
            cmd_send_2_q <= cmd_send_2_d;
            addr2_q      <= addr2_d;
            echo_count_q <= echo_count_d;
            echo_drop_q  <= echo_drop_d;
            first_done_q <= first_done_d;
            ds_prev_q    <= bus.data_saved_2_i;
        end
    end

    always_comb begin
        state2_d     = state2_q;
        cnt2_d       = cnt2_q;
        hold2_d      = hold2_q;
        echo_count_d = echo_count_q;
        first_done_d = first_done_q;
        // Only an armed channel with the link up can service a rise; every other rise is lost.
        echo_drop_d  = (rise && !(state2_q == S2_ARMED && link_ok)) ? sat_inc(echo_drop_q) : echo_drop_q;

        if (state2_q != S2_IDLE && !link_ok) begin
            state2_d = S2_IDLE;
            cnt2_d   = 32'd0;
        end else begin
            case (state2_q)
                S2_IDLE: begin
                    if (link_ok) begin
                        if (ALLOW_FIRST && !first_done_q) begin
                            state2_d = S2_FIRST_WAIT;
                            cnt2_d   = 32'd0;
                        end else begin
                            state2_d = S2_ARMED;
                        end
                    end
                end
                S2_FIRST_WAIT: begin
                    if (cnt2_q == FIRST_DELAY - 32'd1) begin
                        state2_d = S2_FIRST_HOLD;
                        hold2_d  = CMD_HOLD - 8'd1;
                        cnt2_d   = 32'd0;
                    end else begin
                        cnt2_d = cnt2_q + 32'd1;
                    end
                end
                S2_FIRST_HOLD: begin
                    // The initial send is only credited once it completes untruncated.
                    if (hold2_q == 8'd0) begin
                        state2_d     = S2_ARMED;
                        first_done_d = 1'b1;
                        echo_count_d = sat_inc(echo_count_q);
                    end else begin
                        hold2_d = hold2_q - 8'd1;
                    end
                end
                S2_ARMED: begin
                    if (rise) begin
                        state2_d     = S2_ECHO_HOLD;
                        hold2_d      = CMD_HOLD - 8'd1;
                        echo_count_d = sat_inc(echo_count_q);
                    end
                end
                S2_ECHO_HOLD: begin
                    if (hold2_q == 8'd0) state2_d = bus.data_saved_2_i ? S2_WAIT_CLR : S2_ARMED;
                    else                 hold2_d  = hold2_q - 8'd1;
                end
                S2_WAIT_CLR: begin
                    if (!bus.data_saved_2_i) state2_d = S2_ARMED;
                end
                default: state2_d = S2_IDLE;
            endcase
        end
        cmd_send_2_d = (state2_d == S2_FIRST_HOLD) || (state2_d == S2_ECHO_HOLD);
        addr2_d = (cmd_send_2_d && !cmd_send_2_q) ? START_ADDR_2 : addr2_q;
    end

    assign bus.cmd_send_1_o       = cmd_send_1_q;
    assign bus.start_ram_addr_1_o = addr1_q;
    assign bus.cmd_send_2_o       = cmd_send_2_q;
    assign bus.start_ram_addr_2_o = addr2_q;
    assign bus.tx_count_1_o       = tx_count_1_q;
    assign bus.echo_count_o       = echo_count_q;
    assign bus.echo_drop_o        = echo_drop_q;
    assign bus.first_done_o       = first_done_q;

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// Scoreboard bench for pkt_send_scheduler: a reference model pushes expected pulses and status
// snapshots into queues on each clock edge; a negedge monitor pops and compares them.
// Directed phases cover reset, periodic sends, echo, drop, link loss and counter saturation.
module tb_pkt_send_scheduler;
    localparam logic [31:0] P   = 32'd16;
    localparam logic [31:0] FD  = 32'd20;
    localparam logic [7:0]  H   = 8'd3;
    localparam logic [24:0] A1  = 25'd1;
    localparam logic [24:0] A2  = 25'd5;

    logic clk_50_pll = 1'b0;
    logic main_reset = 1'b1;
    always #5 clk_50_pll = ~clk_50_pll;

    pkt_send_scheduler_if sif();

    pkt_send_scheduler #(
        .PERIOD_1(P), .FIRST_DELAY(FD), .ALLOW_FIRST(1'b1), .CMD_HOLD(H),
        .START_ADDR_1(A1), .START_ADDR_2(A2)
    ) dut (
        .clk_50_pll(clk_50_pll),
        .main_reset(main_reset),
        .bus(sif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    typedef struct { int st; int en; logic [15:0] cnt; } pulse_t;
    typedef struct { logic [15:0] tx; logic [15:0] ec; logic [15:0] dr; logic fd; } stat_t;
    pulse_t q1[$];
    pulse_t q2[$];
    stat_t  qs[$];

    // ---------------- reference model (edge-stepped, behavioural) ----------------
    int          cyc = 0;
    int          sat_req = 0, sat_seen = 0;
    logic [15:0] m_tx = 0, m_ec = 0, m_dr = 0;
    bit          m_fd = 0, m_ds_prev = 0;
    bit          m1_act = 0, m1_on = 0;
    int          m1_t = 0, m1_left = 0, m1_st = 0;
    bit          m2_act = 0, m2_pend = 0, m2_on = 0, m2_first = 0, m2_wclr = 0;
    int          m2_t = 0, m2_left = 0, m2_st = 0;

    always @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            m_tx = 0; m_ec = 0; m_dr = 0; m_fd = 0; m_ds_prev = 0;
            m1_act = 0; m1_on = 0; m1_t = 0;
            m2_act = 0; m2_pend = 0; m2_on = 0; m2_wclr = 0; m2_t = 0;
            sat_seen = sat_req;
        end else begin
            bit link, ds, rise;
            cyc++;
            if (sat_req != sat_seen) begin
                m_tx = 16'hFFFE;
                sat_seen = sat_req;
            end
            link = sif.mac_inited_i & sif.rx_ready_i;
            ds   = sif.data_saved_2_i;
            rise = ds & ~m_ds_prev;
            m_ds_prev = ds;

            // channel 1: pulse every P edges of continuous link-up time
            if (!m1_act) begin
                if (link) begin m1_act = 1; m1_t = 0; end
            end else if (!link) begin
                if (m1_on) begin q1.push_back('{m1_st, cyc, m_tx}); m1_on = 0; end
                m1_act = 0;
            end else begin
                m1_t++;
                if (m1_on) begin
                    m1_left--;
                    if (m1_left == 0) begin m1_on = 0; q1.push_back('{m1_st, cyc, m_tx}); end
                end
                if (m1_t % int'(P) == 0) begin
                    m1_on = 1; m1_st = cyc; m1_left = int'(H); m_tx = inc16(m_tx);
                end
            end

            // channel 2 (initial send enabled in this bench)
            if (!m2_act) begin
                if (rise) m_dr = inc16(m_dr);
                if (link) begin m2_act = 1; m2_pend = !m_fd; m2_t = 0; m2_wclr = 0; end
            end else if (!link) begin
                if (rise) m_dr = inc16(m_dr);
                if (m2_on) begin q2.push_back('{m2_st, cyc, m_ec}); m2_on = 0; end
                m2_act = 0; m2_pend = 0; m2_wclr = 0;
            end else if (m2_on) begin
                if (rise) m_dr = inc16(m_dr);
                m2_left--;
                if (m2_left == 0) begin
                    m2_on = 0;
                    if (m2_first) begin m_fd = 1; m_ec = inc16(m_ec); end
                    else m2_wclr = ds;
                    q2.push_back('{m2_st, cyc, m_ec});
                end
            end else if (m2_pend) begin
                if (rise) m_dr = inc16(m_dr);
                m2_t++;
                if (m2_t == int'(FD)) begin
                    m2_pend = 0; m2_on = 1; m2_first = 1; m2_st = cyc; m2_left = int'(H);
                end
            end else if (m2_wclr) begin
                if (rise) m_dr = inc16(m_dr);
                if (!ds) m2_wclr = 0;
            end else if (rise) begin
                m2_on = 1; m2_first = 0; m2_st = cyc; m2_left = int'(H); m_ec = inc16(m_ec);
            end

            if (cyc % 16 == 0) qs.push_back('{m_tx, m_ec, m_dr, m_fd});
        end
    end

    // ---------------- monitor ----------------
    bit     in1 = 0, in2 = 0;
    int     s1 = 0, s2 = 0;
    pulse_t e1, e2;
    stat_t  es;

    always @(negedge clk_50_pll) begin
        if (main_reset) begin
            in1 = 0; in2 = 0;
        end else begin
            if (sif.cmd_send_1_o && !in1) begin
                in1 = 1; s1 = cyc;
                chk("addr1", 32'(sif.start_ram_addr_1_o), 32'(A1));
            end else if (!sif.cmd_send_1_o && in1) begin
                in1 = 0;
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pulse1_unexpected: pulse %0d..%0d, none expected", s1, cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("p1_start", s1, e1.st);
                    chk("p1_end", cyc, e1.en);
                    chk("p1_txcount", 32'(sif.tx_count_1_o), 32'(e1.cnt));
                end
            end
            if (sif.cmd_send_2_o && !in2) begin
                in2 = 1; s2 = cyc;
                chk("addr2", 32'(sif.start_ram_addr_2_o), 32'(A2));
            end else if (!sif.cmd_send_2_o && in2) begin
                in2 = 0;
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pulse2_unexpected: pulse %0d..%0d, none expected", s2, cyc);
                end else begin
                    e2 = q2.pop_front();
                    chk("p2_start", s2, e2.st);
                    chk("p2_end", cyc, e2.en);
                    chk("p2_echocount", 32'(sif.echo_count_o), 32'(e2.cnt));
                end
            end
            while (qs.size() > 0) begin
                es = qs.pop_front();
                chk("st_tx", 32'(sif.tx_count_1_o), 32'(es.tx));
                chk("st_echo", 32'(sif.echo_count_o), 32'(es.ec));
                chk("st_drop", 32'(sif.echo_drop_o), 32'(es.dr));
                chk("st_first", 32'(sif.first_done_o), 32'(es.fd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_50_pll);
        #1;
    endtask

    task automatic wait_cmd1();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50_pll);
            if (sif.cmd_send_1_o) begin ok = 1; break; end
        end
        chk("wait_cmd1_timeout", 32'(ok), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd1"},  32'(sif.cmd_send_1_o), 0);
        chk({tag, "_cmd2"},  32'(sif.cmd_send_2_o), 0);
        chk({tag, "_addr1"}, 32'(sif.start_ram_addr_1_o), 0);
        chk({tag, "_addr2"}, 32'(sif.start_ram_addr_2_o), 0);
        chk({tag, "_tx"},    32'(sif.tx_count_1_o), 0);
        chk({tag, "_echo"},  32'(sif.echo_count_o), 0);
        chk({tag, "_drop"},  32'(sif.echo_drop_o), 0);
        chk({tag, "_first"}, 32'(sif.first_done_o), 0);
    endtask

    initial begin
        int down_left;
        sif.mac_inited_i   = 1'b0;
        sif.rx_ready_i     = 1'b0;
        sif.data_saved_2_i = 1'b0;
        tick(3);
        chk_all_zero("reset");
        main_reset = 1'b0;
        tick(1);

        // periodic sends and initial send
        sif.mac_inited_i = 1'b1;
        sif.rx_ready_i   = 1'b1;
        tick(60);
        chk("tx_after_3", 32'(sif.tx_count_1_o), 32'd3);
        chk("first_done", 32'(sif.first_done_o), 32'd1);
        chk("echo_after_first", 32'(sif.echo_count_o), 32'd1);

        // echo: one pulse for a held level
        sif.data_saved_2_i = 1'b1;
        tick(10);
        sif.data_saved_2_i = 1'b0;
        tick(6);
        chk("echo_once", 32'(sif.echo_count_o), 32'd2);
        chk("no_drop_yet", 32'(sif.echo_drop_o), 32'd0);

        // drop: second rise while the echo pulse is still held
        sif.data_saved_2_i = 1'b1; tick(1);
        sif.data_saved_2_i = 1'b0; tick(1);
        sif.data_saved_2_i = 1'b1; tick(2);
        sif.data_saved_2_i = 1'b0; tick(6);
        chk("echo_after_drop", 32'(sif.echo_count_o), 32'd3);
        chk("drop_one", 32'(sif.echo_drop_o), 32'd1);

        // link loss during a channel-1 pulse
        wait_cmd1();
        sif.rx_ready_i = 1'b0;
        tick(1);
        chk("cmd1_truncated", 32'(sif.cmd_send_1_o), 32'd0);
        tick(4);
        sif.rx_ready_i = 1'b1;
        tick(25);
        chk("first_kept", 32'(sif.first_done_o), 32'd1);
        chk("no_second_first", 32'(sif.echo_count_o), 32'd3);

        // randomized traffic with occasional link dropouts
        down_left = 0;
        for (int i = 0; i < 2500; i++) begin
            tick(1);
            if (down_left > 0) begin
                down_left--;
                if (down_left == 0) sif.rx_ready_i = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                sif.rx_ready_i = 1'b0;
                down_left = $urandom_range(1, 25);
            end
            if ($urandom_range(0, 5) == 0) sif.data_saved_2_i = ~sif.data_saved_2_i;
        end
        sif.rx_ready_i     = 1'b1;
        sif.data_saved_2_i = 1'b0;
        tick(4);

        // asynchronous reset in the middle of a channel-1 pulse
        wait_cmd1();
        main_reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        tick(2);
        main_reset = 1'b0;

        // saturation of the channel-1 counter
        tick(2);
        force dut.tx_count_1_q = 16'hFFFE;
        #1;
        release dut.tx_count_1_q;
        sat_req++;
        tick(40);
        chk("tx_saturated", 32'(sif.tx_count_1_o), 32'h0000FFFF);

        // drain and confirm every expected pulse was observed
        sif.rx_ready_i = 1'b0;
        tick(8);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pkt_send_scheduler.md
Name: pkt_send_scheduler

Overview:
- Generates the transmit command handshakes for the two send_packet controllers in system_design.
- Channel 1 issues periodic sends from a fixed RAM address.
- Channel 2 echoes: it answers every data_saved rising edge from the receive side with a send. It can also issue one initial send.
- Both channels are gated by link readiness (mac_inited and rx_ready). The block keeps saturating activity counters for status readback.

Parameters:
- PERIOD_1, 32'd100_000_000, channel-1 pulse-start-to-pulse-start interval in clk_50_pll cycles (min CMD_HOLD+2).
- FIRST_DELAY, 32'd117_000_000, cycles from link-ready to the channel-2 initial send.
- ALLOW_FIRST, 1'b0, enables the channel-2 initial send.
- CMD_HOLD, 8'd3, cmd_send pulse width in cycles (min 1).
- START_ADDR_1, 25'd1, RAM start address for channel 1.
- START_ADDR_2, 25'd5, RAM start address for channel 2.

Ports:
- clk_50_pll  in  1  system clock.
- main_reset  in  1  async reset, active-high.
- mac_inited_i  in  1  MAC configuration done.
- rx_ready_i  in  1  PHY reset controller rx_ready.
- data_saved_2_i  in  1  channel-2 receive buffer holds a frame (level, same clock domain).
- cmd_send_1_o  out  1  channel-1 send request.
- start_ram_addr_1_o  out  25  channel-1 start address.
- cmd_send_2_o  out  1  channel-2 send request.
- start_ram_addr_2_o  out  25  channel-2 start address.
- tx_count_1_o  out  16  channel-1 pulses issued.
- echo_count_o  out  16  channel-2 pulses issued (initial send plus echoes).
- echo_drop_o  out  16  data_saved rising edges not serviced.
- first_done_o  out  1  channel-2 initial send completed.

Behaviour:
- Reset and clocking:
  - Reset is main_reset, asynchronous, active-high; the clock is clk_50_pll.
  - On reset all outputs are 0, all counters are 0, both FSMs are in IDLE, and first_done is cleared.
- Gating: link_ok = mac_inited_i & rx_ready_i, sampled each cycle, unregistered.
- Address outputs:
  - start_ram_addr_1_o is loaded with START_ADDR_1 on the edge cmd_send_1_o rises; start_ram_addr_2_o likewise with START_ADDR_2.
  - Each holds its value until the next load, so it is stable throughout every pulse.
- Channel 1 FSM (IDLE, COUNT, ASSERT):
  - IDLE -> COUNT when link_ok; cnt1 = 0.
  - In COUNT/ASSERT, cnt1 increments every cycle and wraps to 0 after PERIOD_1-1.
  - On the edge where cnt1 == PERIOD_1-1: go to ASSERT, drive cmd_send_1_o = 1, increment tx_count_1.
  - The first pulse rises PERIOD_1 edges after link_ok is first sampled high.
  - ASSERT lasts exactly CMD_HOLD cycles, then returns to COUNT.
- Channel 2 initial send (only when ALLOW_FIRST = 1 and !first_done):
  - cnt2 counts link_ok cycles; at cnt2 == FIRST_DELAY-1 go to FIRST_HOLD.
  - FIRST_HOLD drives cmd_send_2_o for CMD_HOLD cycles, then sets first_done, increments echo_count and goes to ARMED.
  - If ALLOW_FIRST = 0, go IDLE -> ARMED on link_ok.
- Channel 2 echo FSM (ARMED, ECHO_HOLD, WAIT_CLR):
  - Edge detection: a rise means data_saved_2_i = 1 with its registered previous value = 0.
  - ARMED + rise: cmd_send_2_o = 1 from the next edge (1-cycle latency); go to ECHO_HOLD; increment echo_count.
  - ECHO_HOLD lasts CMD_HOLD cycles, then goes to WAIT_CLR.
  - WAIT_CLR -> ARMED once data_saved_2_i == 0; ARMED directly if it is already 0.
  - A rise detected in any state other than ARMED (IDLE, first-send wait, FIRST_HOLD, ECHO_HOLD) increments echo_drop and is not queued.
- Link loss (link_ok = 0) in any non-IDLE state:
  - The affected FSM goes to IDLE on the next edge and its cmd_send drops on that same edge (pulse truncated).
  - cnt1/cnt2 clear to 0.
  - Counters, first_done and the address outputs are retained.
  - On link restore, period and first-delay timing restart from 0. The initial send is not repeated if first_done = 1.
- Counters: all three are 16-bit and saturate at 16'hFFFF (no wrap).
- Simultaneous events: a rise on the same edge that a pulse ends counts as a drop. A rise on the edge link_ok drops counts as a drop.

Test Plan (PERIOD_1 = 16, CMD_HOLD = 3, FIRST_DELAY = 20 unless noted):
- Reset mid-pulse: assert main_reset while cmd_send_1_o = 1 -> all outputs 0 immediately (asynchronous), before the next edge; the counters read 0.
- Periodic: link_ok high at edge 0 -> cmd_send_1_o high for edges 16-18, 32-34, 48-50, with addr = 1. After 3 pulses tx_count_1_o = 3.
- Echo: data_saved_2_i rises before edge 100 and is held 10 cycles -> cmd_send_2_o high edges 100-102 with addr = 5. echo_count_o = 1 and no second pulse until data_saved_2_i falls and rises again.
- Drop: data_saved pulses low-high within ECHO_HOLD -> echo_drop_o = 1, no extra cmd_send_2.
- Initial send (ALLOW_FIRST = 1): link_ok at edge 0 -> cmd_send_2_o high edges 20-22 and first_done_o = 1. After a link drop and restore there is no second initial send.
- Link loss: rx_ready_i drops during a channel-1 pulse -> cmd_send_1_o = 0 on the next edge. After restore, the next pulse comes 16 edges later.
- Saturation (force counter near max) -> tx_count_1_o holds at 16'hFFFF.
